// File: rtl/forth_regfile_v2_if.sv
`default_nettype none
// ============================================================================
// Module   : forth_regfile_v2_if
// Brief    : Decoder/sequencer <-> register file bundle for the Forth core.
// Revision : 1.0  initial release
// ============================================================================
interface forth_regfile_v2_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) ();
  logic [1:0]        i_SSRSet;
  logic [ADDR_W-1:0] i_RADDRA;
  logic [ADDR_W-1:0] i_RADDRB;
  logic [ADDR_W-1:0] i_WADDR;
  logic [DATA_W-1:0] i_DATA;
  logic              f_WRITE;
  logic [DATA_W-1:0] i_PCDATA;
  logic              f_PCLOAD;
  logic [1:0]        i_PSPOP;
  logic [1:0]        i_RSPOP;
  logic              f_ERRCLR;
  logic              o_SSR;
  logic [DATA_W-1:0] o_PC;
  logic [DATA_W-1:0] o_PSP;
  logic [DATA_W-1:0] o_RSP;
  logic [DATA_W-1:0] o_OfR;
  logic [DATA_W-1:0] o_OUTA;
  logic [DATA_W-1:0] o_OUTB;
  logic              o_PSPERR;
  logic              o_RSPERR;

  modport master (
    output i_SSRSet, i_RADDRA, i_RADDRB, i_WADDR, i_DATA, f_WRITE,
           i_PCDATA, f_PCLOAD, i_PSPOP, i_RSPOP, f_ERRCLR,
    input  o_SSR, o_PC, o_PSP, o_RSP, o_OfR, o_OUTA, o_OUTB,
           o_PSPERR, o_RSPERR
  );

  modport slave (
    input  i_SSRSet, i_RADDRA, i_RADDRB, i_WADDR, i_DATA, f_WRITE,
           i_PCDATA, f_PCLOAD, i_PSPOP, i_RSPOP, f_ERRCLR,
    output o_SSR, o_PC, o_PSP, o_RSP, o_OfR, o_OUTA, o_OUTB,
           o_PSPERR, o_RSPERR
  );
endinterface
`default_nettype wire

// File: rtl/forth_regfile_v2.sv
`default_nettype none
// ============================================================================
// Module   : forth_regfile_v2
// Brief    : Forth CPU register file: PC/PSP/RSP/OfR roles, two bypassed
//            registered read ports, bounded stack-pointer push/pop.
// Revision : 1.0  initial release
// ============================================================================
module forth_regfile_v2 #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 16,
  parameter int PSP_BASE  = 48,
  parameter int PSP_LIMIT = 55,
  parameter int RSP_BASE  = 56,
  parameter int RSP_LIMIT = 63
) (
  input  wire logic           c_CLOCK,
  input  wire logic           c_RESET,
  forth_regfile_v2_if.slave   bus
);

  localparam int                c_ADDR_W    = $clog2(NUM_REGS);
  localparam logic [DATA_W-1:0] c_ONE       = DATA_W'(1);
  localparam logic [DATA_W-1:0] c_PSP_BASE  = DATA_W'(PSP_BASE);
  localparam logic [DATA_W-1:0] c_PSP_LIMIT = DATA_W'(PSP_LIMIT);
  localparam logic [DATA_W-1:0] c_RSP_BASE  = DATA_W'(RSP_BASE);
  localparam logic [DATA_W-1:0] c_RSP_LIMIT = DATA_W'(RSP_LIMIT);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   w_next [NUM_REGS];
  logic [NUM_REGS-1:0] w_wr_sel;
  logic [DATA_W:0]     w_psp_step;
  logic [DATA_W:0]     w_rsp_step;
  logic                w_psp_evt;
  logic                w_rsp_evt;
  logic [DATA_W-1:0]   r_outa;
  logic [DATA_W-1:0]   r_outb;
  logic                r_ssr;
  logic                r_psp_err;
  logic                r_rsp_err;

  // Result is {error, next value}; bounds are equality checks so an
  // out-of-range pointer simply walks (and wraps) without flagging.
  function automatic logic [DATA_W:0] stack_step(
    input logic [DATA_W-1:0] cur,
    input logic [1:0]        op,
    input logic [DATA_W-1:0] lo,
    input logic [DATA_W-1:0] hi
  );
    logic [DATA_W:0] res;
    res = {1'b0, cur};
    case (op)
      2'b01:   res = (cur != hi) ? {1'b0, cur + c_ONE} : {1'b1, cur};
      2'b10:   res = (cur != lo) ? {1'b0, cur - c_ONE} : {1'b1, cur};
      default: res = {1'b0, cur};
    endcase
    return res;
  endfunction

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_wr_dec
      assign w_wr_sel[g] = bus.f_WRITE && (bus.i_WADDR == c_ADDR_W'(g));
    end
  endgenerate

  assign w_psp_step = stack_step(r_regs[1], bus.i_PSPOP, c_PSP_BASE, c_PSP_LIMIT);
  assign w_rsp_step = stack_step(r_regs[2], bus.i_RSPOP, c_RSP_BASE, c_RSP_LIMIT);

  // A direct write to a pointer pre-empts its stack op and suppresses errors.
  always_comb begin
    w_psp_evt = 1'b0;
    w_rsp_evt = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_next[i] = w_wr_sel[i] ? bus.i_DATA : r_regs[i];
    end
    if (!w_wr_sel[0] && bus.f_PCLOAD) begin
      w_next[0] = bus.i_PCDATA;
    end
    if (!w_wr_sel[1]) begin
      w_next[1] = w_psp_step[DATA_W-1:0];
      w_psp_evt = w_psp_step[DATA_W];
    end
    if (!w_wr_sel[2]) begin
      w_next[2] = w_rsp_step[DATA_W-1:0];
      w_rsp_evt = w_rsp_step[DATA_W];
    end
  end

  always_ff @(posedge c_CLOCK or posedge c_RESET) begin
    if (c_RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[1] <= c_PSP_BASE;
      r_regs[2] <= c_RSP_BASE;
      r_outa    <= '0;
      r_outb    <= '0;
      r_ssr     <= 1'b0;
      r_psp_err <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      r_regs    <= w_next;
      // Read ports sample next-state so same-edge updates are visible.
      r_outa    <= w_next[bus.i_RADDRA];
      r_outb    <= w_next[bus.i_RADDRB];
      if (!bus.i_SSRSet[1]) begin
        r_ssr <= bus.i_SSRSet[0];
      end
      r_psp_err <= w_psp_evt | (r_psp_err & ~bus.f_ERRCLR);
      r_rsp_err <= w_rsp_evt | (r_rsp_err & ~bus.f_ERRCLR);
    end
  end

  assign bus.o_PC     = r_regs[0];
  assign bus.o_PSP    = r_regs[1];
  assign bus.o_RSP    = r_regs[2];
  assign bus.o_OfR    = r_regs[3];
  assign bus.o_OUTA   = r_outa;
  assign bus.o_OUTB   = r_outb;
  assign bus.o_SSR    = r_ssr;
  assign bus.o_PSPERR = r_psp_err;
  assign bus.o_RSPERR = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_forth_regfile_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_forth_regfile_v2
// Brief    : Self-checking bench for forth_regfile_v2 (directed + random).
// Revision : 1.0  initial release
// ============================================================================
module tb_forth_regfile_v2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  forth_regfile_v2_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  forth_regfile_v2 #(
    .DATA_W(16), .NUM_REGS(16), .PSP_BASE(48), .PSP_LIMIT(55),
    .RSP_BASE(56), .RSP_LIMIT(63)
  ) dut (
    .c_CLOCK (clk),
    .c_RESET (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_regs [16];
  logic [15:0] m_outa, m_outb;
  logic        m_ssr, m_perr, m_rerr;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_regs[1] = 16'd48;
    m_regs[2] = 16'd56;
    m_outa = 16'h0; m_outb = 16'h0;
    m_ssr = 1'b0; m_perr = 1'b0; m_rerr = 1'b0;
  endtask

  task automatic m_step();
    logic [15:0] nxt [16];
    logic pe, re;
    pe = 1'b0; re = 1'b0;
    nxt = m_regs;
    if (bus.f_WRITE) nxt[bus.i_WADDR] = bus.i_DATA;
    if (!(bus.f_WRITE && bus.i_WADDR == 4'd0) && bus.f_PCLOAD) nxt[0] = bus.i_PCDATA;
    if (!(bus.f_WRITE && bus.i_WADDR == 4'd1)) begin
      if (bus.i_PSPOP == 2'b01) begin
        if (m_regs[1] == 16'd55) pe = 1'b1; else nxt[1] = m_regs[1] + 16'd1;
      end else if (bus.i_PSPOP == 2'b10) begin
        if (m_regs[1] == 16'd48) pe = 1'b1; else nxt[1] = m_regs[1] - 16'd1;
      end
    end
    if (!(bus.f_WRITE && bus.i_WADDR == 4'd2)) begin
      if (bus.i_RSPOP == 2'b01) begin
        if (m_regs[2] == 16'd63) re = 1'b1; else nxt[2] = m_regs[2] + 16'd1;
      end else if (bus.i_RSPOP == 2'b10) begin
        if (m_regs[2] == 16'd56) re = 1'b1; else nxt[2] = m_regs[2] - 16'd1;
      end
    end
    m_perr = pe ? 1'b1 : (bus.f_ERRCLR ? 1'b0 : m_perr);
    m_rerr = re ? 1'b1 : (bus.f_ERRCLR ? 1'b0 : m_rerr);
    if (bus.i_SSRSet < 2'd2) m_ssr = bus.i_SSRSet[0];
    m_outa = nxt[bus.i_RADDRA];
    m_outb = nxt[bus.i_RADDRB];
    m_regs = nxt;
  endtask

  task automatic set_idle();
    bus.i_SSRSet = 2'd2; bus.i_RADDRA = 4'd0; bus.i_RADDRB = 4'd0;
    bus.i_WADDR = 4'd0; bus.i_DATA = 16'h0; bus.f_WRITE = 1'b0;
    bus.i_PCDATA = 16'h0; bus.f_PCLOAD = 1'b0; bus.i_PSPOP = 2'b00;
    bus.i_RSPOP = 2'b00; bus.f_ERRCLR = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    apply_reset();
    bus.i_RADDRA = 4'd1; bus.i_RADDRB = 4'd2;
    tick();
    n_total++; if (bus.o_PSP !== 16'd48) $display("FAIL reset_psp: got %0d want 48", bus.o_PSP); else n_pass++;
    n_total++; if (bus.o_RSP !== 16'd56) $display("FAIL reset_rsp: got %0d want 56", bus.o_RSP); else n_pass++;
    n_total++; if (bus.o_OUTA !== 16'd48) $display("FAIL reset_outa: got %0d want 48", bus.o_OUTA); else n_pass++;
    n_total++; if (bus.o_OUTB !== 16'd56) $display("FAIL reset_outb: got %0d want 56", bus.o_OUTB); else n_pass++;
    n_total++; if (bus.o_PC !== 16'd0) $display("FAIL reset_pc: got %0d want 0", bus.o_PC); else n_pass++;
    n_total++; if ({bus.o_SSR, bus.o_PSPERR, bus.o_RSPERR} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {bus.o_SSR, bus.o_PSPERR, bus.o_RSPERR}); else n_pass++;
  endtask

  task automatic test_psp_bounds();
    set_idle();
    bus.i_PSPOP = 2'b01;
    for (int k = 0; k < 7; k++) tick();
    n_total++; if (bus.o_PSP !== 16'd55) $display("FAIL psp_push7: got %0d want 55", bus.o_PSP); else n_pass++;
    n_total++; if (bus.o_PSPERR !== 1'b0) $display("FAIL psp_push7_err: got %b want 0", bus.o_PSPERR); else n_pass++;
    tick();
    n_total++; if (bus.o_PSP !== 16'd55) $display("FAIL psp_overflow_hold: got %0d want 55", bus.o_PSP); else n_pass++;
    n_total++; if (bus.o_PSPERR !== 1'b1) $display("FAIL psp_overflow_err: got %b want 1", bus.o_PSPERR); else n_pass++;
    bus.i_PSPOP = 2'b00; bus.f_ERRCLR = 1'b1;
    tick();
    n_total++; if (bus.o_PSPERR !== 1'b0) $display("FAIL psp_errclr: got %b want 0", bus.o_PSPERR); else n_pass++;
    bus.f_ERRCLR = 1'b0; bus.i_PSPOP = 2'b10;
    for (int k = 0; k < 7; k++) tick();
    n_total++; if (bus.o_PSP !== 16'd48) $display("FAIL psp_pop7: got %0d want 48", bus.o_PSP); else n_pass++;
    n_total++; if (bus.o_PSPERR !== 1'b0) $display("FAIL psp_pop7_err: got %b want 0", bus.o_PSPERR); else n_pass++;
    tick();
    n_total++; if (bus.o_PSP !== 16'd48) $display("FAIL psp_underflow_hold: got %0d want 48", bus.o_PSP); else n_pass++;
    n_total++; if (bus.o_PSPERR !== 1'b1) $display("FAIL psp_underflow_err: got %b want 1", bus.o_PSPERR); else n_pass++;
    bus.f_ERRCLR = 1'b1;
    tick();
    n_total++; if (bus.o_PSPERR !== 1'b1) $display("FAIL psp_clr_vs_new_err: got %b want 1", bus.o_PSPERR); else n_pass++;
    bus.i_PSPOP = 2'b00;
    tick();
    n_total++; if (bus.o_PSPERR !== 1'b0) $display("FAIL psp_clr_again: got %b want 0", bus.o_PSPERR); else n_pass++;
  endtask

  task automatic test_pc_priority();
    set_idle();
    bus.f_WRITE = 1'b1; bus.i_WADDR = 4'd0; bus.i_DATA = 16'h1234;
    bus.f_PCLOAD = 1'b1; bus.i_PCDATA = 16'h0002; bus.i_RADDRA = 4'd0;
    tick();
    n_total++; if (bus.o_PC !== 16'h1234) $display("FAIL pc_write_wins: got %h want 1234", bus.o_PC); else n_pass++;
    n_total++; if (bus.o_OUTA !== 16'h1234) $display("FAIL pc_bypass_outa: got %h want 1234", bus.o_OUTA); else n_pass++;
    bus.f_WRITE = 1'b0;
    tick();
    n_total++; if (bus.o_PC !== 16'h0002) $display("FAIL pc_load: got %h want 0002", bus.o_PC); else n_pass++;
  endtask

  task automatic test_rsp_write_override();
    set_idle();
    bus.f_WRITE = 1'b1; bus.i_WADDR = 4'd2; bus.i_DATA = 16'h00F0; bus.i_RSPOP = 2'b10;
    tick();
    n_total++; if (bus.o_RSP !== 16'h00F0) $display("FAIL rsp_write_wins: got %h want 00f0", bus.o_RSP); else n_pass++;
    n_total++; if (bus.o_RSPERR !== 1'b0) $display("FAIL rsp_write_noerr: got %b want 0", bus.o_RSPERR); else n_pass++;
    bus.i_DATA = 16'hFFFF; bus.i_RSPOP = 2'b00;
    tick();
    bus.f_WRITE = 1'b0; bus.i_RSPOP = 2'b01;
    tick();
    n_total++; if (bus.o_RSP !== 16'h0000) $display("FAIL rsp_wrap: got %h want 0000", bus.o_RSP); else n_pass++;
    n_total++; if (bus.o_RSPERR !== 1'b0) $display("FAIL rsp_wrap_noerr: got %b want 0", bus.o_RSPERR); else n_pass++;
  endtask

  task automatic test_regs_and_ssr();
    set_idle();
    bus.f_WRITE = 1'b1; bus.i_WADDR = 4'd9; bus.i_DATA = 16'hBEEF;
    bus.i_RADDRA = 4'd9; bus.i_RADDRB = 4'd9;
    tick();
    n_total++; if (bus.o_OUTA !== 16'hBEEF) $display("FAIL r9_outa: got %h want beef", bus.o_OUTA); else n_pass++;
    n_total++; if (bus.o_OUTB !== 16'hBEEF) $display("FAIL r9_outb: got %h want beef", bus.o_OUTB); else n_pass++;
    bus.f_WRITE = 1'b0; bus.i_SSRSet = 2'd1;
    tick();
    n_total++; if (bus.o_SSR !== 1'b1) $display("FAIL ssr_set: got %b want 1", bus.o_SSR); else n_pass++;
    bus.i_SSRSet = 2'd3;
    tick();
    n_total++; if (bus.o_SSR !== 1'b1) $display("FAIL ssr_hold: got %b want 1", bus.o_SSR); else n_pass++;
    bus.i_SSRSet = 2'd0;
    tick();
    n_total++; if (bus.o_SSR !== 1'b0) $display("FAIL ssr_clear: got %b want 0", bus.o_SSR); else n_pass++;
  endtask

  task automatic test_random();
    int fails_here;
    fails_here = 0;
    set_idle();
    apply_reset();
    m_reset();
    for (int c = 0; c < 600; c++) begin
      bus.i_SSRSet = 2'($urandom_range(0, 3));
      bus.i_RADDRA = 4'($urandom_range(0, 15));
      bus.i_RADDRB = ($urandom_range(0, 3) == 0) ? bus.i_RADDRA : 4'($urandom_range(0, 15));
      bus.i_WADDR  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      bus.i_DATA   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(46, 65)) : 16'($urandom);
      bus.f_WRITE  = ($urandom_range(0, 4) == 0);
      bus.i_PCDATA = 16'($urandom);
      bus.f_PCLOAD = ($urandom_range(0, 2) == 0);
      bus.i_PSPOP  = 2'($urandom_range(0, 3));
      bus.i_RSPOP  = 2'($urandom_range(0, 3));
      bus.f_ERRCLR = ($urandom_range(0, 7) == 0);
      m_step();
      tick();
      n_total++; if (bus.o_PC !== m_regs[0]) $display("FAIL rnd_pc c=%0d: got %h want %h", c, bus.o_PC, m_regs[0]); else n_pass++;
      n_total++; if (bus.o_PSP !== m_regs[1]) $display("FAIL rnd_psp c=%0d: got %h want %h", c, bus.o_PSP, m_regs[1]); else n_pass++;
      n_total++; if (bus.o_RSP !== m_regs[2]) $display("FAIL rnd_rsp c=%0d: got %h want %h", c, bus.o_RSP, m_regs[2]); else n_pass++;
      n_total++; if (bus.o_OfR !== m_regs[3]) $display("FAIL rnd_ofr c=%0d: got %h want %h", c, bus.o_OfR, m_regs[3]); else n_pass++;
      n_total++; if (bus.o_OUTA !== m_outa) $display("FAIL rnd_outa c=%0d: got %h want %h", c, bus.o_OUTA, m_outa); else n_pass++;
      n_total++; if (bus.o_OUTB !== m_outb) $display("FAIL rnd_outb c=%0d: got %h want %h", c, bus.o_OUTB, m_outb); else n_pass++;
      n_total++; if ({bus.o_SSR, bus.o_PSPERR, bus.o_RSPERR} !== {m_ssr, m_perr, m_rerr})
        $display("FAIL rnd_flags c=%0d: got %b want %b", c, {bus.o_SSR, bus.o_PSPERR, bus.o_RSPERR}, {m_ssr, m_perr, m_rerr});
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    set_idle();
    bus.i_SSRSet = 2'd1; bus.i_PSPOP = 2'b01; bus.i_RSPOP = 2'b01;
    bus.f_WRITE = 1'b1; bus.i_WADDR = 4'd3; bus.i_DATA = 16'h5555;
    bus.i_RADDRA = 4'd3; bus.i_RADDRB = 4'd1;
    for (int k = 0; k < 9; k++) tick();
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus.o_PC !== 16'd0) $display("FAIL areset_pc: got %h want 0", bus.o_PC); else n_pass++;
    n_total++; if (bus.o_PSP !== 16'd48) $display("FAIL areset_psp: got %0d want 48", bus.o_PSP); else n_pass++;
    n_total++; if (bus.o_RSP !== 16'd56) $display("FAIL areset_rsp: got %0d want 56", bus.o_RSP); else n_pass++;
    n_total++; if (bus.o_OfR !== 16'd0) $display("FAIL areset_ofr: got %h want 0", bus.o_OfR); else n_pass++;
    n_total++; if ({bus.o_OUTA, bus.o_OUTB} !== 32'h0) $display("FAIL areset_outs: got %h want 0", {bus.o_OUTA, bus.o_OUTB}); else n_pass++;
    n_total++; if ({bus.o_SSR, bus.o_PSPERR, bus.o_RSPERR} !== 3'b000)
      $display("FAIL areset_flags: got %b want 000", {bus.o_SSR, bus.o_PSPERR, bus.o_RSPERR}); else n_pass++;
    #2 rst = 1'b0;
    set_idle();
    bus.i_PSPOP = 2'b01;
    tick();
    n_total++; if (bus.o_PSP !== 16'd49) $display("FAIL post_reset_push: got %0d want 49", bus.o_PSP); else n_pass++;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_psp_bounds();
    test_pc_priority();
    test_rsp_write_override();
    test_regs_and_ssr();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
